// File: rtl/data_memory_ws_if.sv
// Request/response bus for the MEM-stage data memory.
//   master : drives req_valid/req_write/req_size/req_signed/req_addr/req_wdata and rsp_ready
//   slave  : drives req_ready, rsp_valid, rsp_rdata, rsp_fault
interface data_memory_ws_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_fault;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/data_memory_ws.sv
// Data memory for the CPU MEM stage with programmable wait states.
// Byte/halfword/word little-endian loads (zero/sign extended) and stores.
// Misaligned, out-of-range and size=11 requests are answered with a fault
// and never touch the array. Storage is not cleared by reset.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : data_memory_ws_if slave (request valid/ready, response valid/ready)
//
// state  | meaning
// IDLE   | req_ready high (from first edge after reset), waiting for a request
// WAIT   | request latched; counting wait states, access on the cnt==0 edge
// RESP   | rsp_valid high, rdata/fault held until rsp_ready
module data_memory_ws #(
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          ADDR_W       = 32,
   parameter int          WAIT_CYCLES  = 1,
   parameter logic [31:0] INIT_PATTERN = 32'hDEADBEEF
) (
   input logic             clk,
   input logic             reset,
   data_memory_ws_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic             write_q, write_d;
   logic [1:0]       size_q, size_d;
   logic             signed_q, signed_d;
   logic [1:0]       lane_q, lane_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rsp_fault_q, rsp_fault_d;

   // Power-on fill; the words at byte addresses 0x0 and 0x4 carry markers.
   logic [31:0] mem_q [DEPTH_WORDS] = '{0: 32'h000000A0, 1: 32'h000000B0, default: INIT_PATTERN};

   logic        accept;
   logic        req_fault;
   logic        access;
   logic        mem_we;
   logic [31:0] rd_word;
   logic [31:0] ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] wr_word;
   logic [3:0]  wr_be;

   assign accept  = bus.req_valid & ready_q;
   assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0) && !fault_q;
   assign mem_we  = access & write_q;
   assign rd_word = mem_q[idx_q];

   assign req_fault = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]))
                    | (|bus.req_addr[ADDR_W-1:IDX_W+2]);

   always_comb begin
      ld_byte = rd_word[{lane_q, 3'b000} +: 8];
      ld_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
      case (size_q)
         2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   // Store data is replicated across lanes; the byte enables pick the target.
   always_comb begin
      case (size_q)
         2'b00: begin
            wr_word = {4{wdata_q[7:0]}};
            wr_be   = 4'b0001 << lane_q;
         end
         2'b01: begin
            wr_word = {2{wdata_q[15:0]}};
            wr_be   = lane_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_word = wdata_q;
            wr_be   = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      write_d     = write_q;
      size_d      = size_q;
      signed_d    = signed_q;
      lane_d      = lane_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_fault_d = rsp_fault_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               write_d  = bus.req_write;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               lane_d   = bus.req_addr[1:0];
               idx_d    = bus.req_addr[IDX_W+1:2];
               wdata_d  = bus.req_wdata;
               fault_d  = req_fault;
               // Faults pass through WAIT with no wait states so the response
               // still appears one edge after acceptance.
               cnt_d    = req_fault ? 4'd0 : 4'(WAIT_CYCLES);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d     = S_RESP;
               rsp_fault_d = fault_q;
               rdata_d     = (fault_q | write_q) ? 32'd0 : ld_data;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rdata_d     = 32'd0;
               rsp_fault_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         lane_q      <= 2'b00;
         idx_q       <= '0;
         wdata_q     <= 32'd0;
         rdata_q     <= 32'd0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
         write_q     <= write_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         lane_q      <= lane_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem_q[idx_q][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_fault = rsp_fault_q;
endmodule
